// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Issue / writeback / operand-read bundle of the scoreboarded
//               register file. The issue and writeback stages drive it as
//               master; the register file is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWR   = 3
);
  localparam int AW = $clog2(NREGS);

  // Operand read ports
  logic [AW-1:0]       rs1;
  logic [AW-1:0]       rs2;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic                rs1_pending;
  logic                rs2_pending;

  // Issue side
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                issue_waw;

  // Writeback ports, port i packed at [i*AW +: AW] / [i*XLEN +: XLEN]
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;

  // Registered count of pending registers
  logic [AW:0]         pending_cnt;

  modport master (
    output rs1, rs2, issue_en, issue_rd, wr_en, wr_addr, wr_data,
    input  rs1_data, rs2_data, rs1_pending, rs2_pending, issue_waw, pending_cnt
  );

  modport slave (
    input  rs1, rs2, issue_en, issue_rd, wr_en, wr_addr, wr_data,
    output rs1_data, rs2_data, rs1_pending, rs2_pending, issue_waw, pending_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Multi-write-port integer register file with per-register
//               pending (busy) bits, WAW stall flag and a registered count of
//               pending registers. Register 0 is hard-wired to zero and is
//               never pending.
// Options     : define REGFILE_BYPASS_EN to forward same-cycle writebacks
//               onto the read ports (0-cycle write-to-read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWR   = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_cnt;

  logic [AW-1:0]    w_wa [NWR];
  logic [XLEN-1:0]  w_wd [NWR];
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_pend_next;
  logic [AW:0]      w_cnt_next;

  logic [XLEN-1:0]  w_rs1_data;
  logic [XLEN-1:0]  w_rs2_data;
  logic             w_rs1_pend;
  logic             w_rs2_pend;

  // Unpack the flat writeback buses into per-port address/data
  generate
    for (genvar gi = 0; gi < NWR; gi++) begin : g_unpack
      assign w_wa[gi] = bus.wr_addr[gi*AW +: AW];
      assign w_wd[gi] = bus.wr_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Per-register set (issue) and clear (any writeback) requests
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_set[r] = bus.issue_en && (bus.issue_rd == AW'(r));
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i] && (w_wa[i] == AW'(r))) w_clr[r] = 1'b1;
      end
    end
  end

  // Next pending state: issue wins over a same-cycle writeback; reg 0 never pending
  always_comb begin
    w_pend_next    = w_set | (r_pend & ~w_clr);
    w_pend_next[0] = 1'b0;
  end

  // Population count of the next pending vector
  always_comb begin
    w_cnt_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_cnt_next = w_cnt_next + (AW+1)'(w_pend_next[r]);
    end
  end

  // Register array write; later (higher-index) ports overwrite earlier ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i] && (w_wa[i] != '0)) r_regs[w_wa[i]] <= w_wd[i];
      end
    end
  end

  // Pending bits and their count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_cnt  <= w_cnt_next;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Operand read with same-cycle writeback forwarding (highest port wins)
  always_comb begin
    logic w_hit1;
    logic w_hit2;
    w_rs1_data = r_regs[bus.rs1];
    w_rs2_data = r_regs[bus.rs2];
    w_rs1_pend = r_pend[bus.rs1];
    w_rs2_pend = r_pend[bus.rs2];
    w_hit1     = 1'b0;
    w_hit2     = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      if (!rst && bus.wr_en[i] && (bus.rs1 != '0) && (w_wa[i] == bus.rs1)) begin
        w_rs1_data = w_wd[i];
        w_hit1     = 1'b1;
      end
      if (!rst && bus.wr_en[i] && (bus.rs2 != '0) && (w_wa[i] == bus.rs2)) begin
        w_rs2_data = w_wd[i];
        w_hit2     = 1'b1;
      end
    end
    // A forwarded write clears pending unless a new issue re-targets the register
    if (w_hit1) w_rs1_pend = bus.issue_en && (bus.issue_rd == bus.rs1);
    if (w_hit2) w_rs2_pend = bus.issue_en && (bus.issue_rd == bus.rs2);
  end
`else
  // Operand read from stored state only
  always_comb begin
    w_rs1_data = r_regs[bus.rs1];
    w_rs2_data = r_regs[bus.rs2];
    w_rs1_pend = r_pend[bus.rs1];
    w_rs2_pend = r_pend[bus.rs2];
  end
`endif

  assign bus.rs1_data    = w_rs1_data;
  assign bus.rs2_data    = w_rs2_data;
  assign bus.rs1_pending = w_rs1_pend;
  assign bus.rs2_pending = w_rs2_pend;
  assign bus.issue_waw   = bus.issue_en && (bus.issue_rd != '0) && r_pend[bus.issue_rd];
  assign bus.pending_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard: a directed vector
//               table plus hand sequences for forwarding and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NWR   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ien;
    logic [4:0]  ird;
    logic [2:0]  wen;
    logic [4:0]  wa0, wa1, wa2;
    logic [31:0] wd0, wd1, wd2;
    logic [4:0]  rs1, rs2;
    logic [31:0] e1d;
    logic        e1p;
    logic [31:0] e2d;
    logic        e2p;
    logic        ewaw;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tv [13];

  function automatic vec_t mk(logic ien, logic [4:0] ird, logic [2:0] wen,
                              logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1,
                              logic [4:0] wa2, logic [31:0] wd2,
                              logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] e1d, logic e1p,
                              logic [31:0] e2d, logic e2p,
                              logic ewaw, logic [5:0] ecnt);
    vec_t v;
    v.ien = ien; v.ird = ird; v.wen = wen;
    v.wa0 = wa0; v.wa1 = wa1; v.wa2 = wa2;
    v.wd0 = wd0; v.wd1 = wd1; v.wd2 = wd2;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e1d = e1d; v.e1p = e1p; v.e2d = e2d; v.e2p = e2p;
    v.ewaw = ewaw; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ien, input logic [4:0] ird, input logic [2:0] wen,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] wa2, input logic [31:0] wd2,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.issue_en = ien;
    bus.issue_rd = ird;
    bus.wr_en    = wen;
    bus.wr_addr  = {wa2, wa1, wa0};
    bus.wr_data  = {wd2, wd1, wd0};
    bus.rs1      = rs1;
    bus.rs2      = rs2;
  endtask

  task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b0, 5'd0, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, rs1, rs2);
  endtask

  // Advance to the next rising edge and step 1 time unit past it
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: inputs applied for one cycle, outputs checked before the edge
    tv[0]  = mk(1, 5, 3'b000, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 5, 3'b000, 0, 0, 0, 0, 0, 0,  5, 1, 0, 1, 0, 0, 1, 1);
    tv[2]  = mk(0, 0, 3'b001, 5, 32'hDEADBEEF, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1);
    tv[3]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,  5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 3'b111, 7, 32'h11, 7, 32'h22, 7, 32'h33, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,  7, 5, 32'h33, 0, 32'hDEADBEEF, 0, 0, 0);
    tv[6]  = mk(1, 0, 3'b111, 0, 32'h11, 0, 32'h22, 0, 32'h33, 7, 0, 32'h33, 0, 0, 0, 0, 0);
    tv[7]  = mk(1, 9, 3'b000, 0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 32'h33, 0, 0, 0);
    tv[8]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,  9, 0, 0, 1, 0, 0, 0, 1);
    tv[9]  = mk(1, 9, 3'b010, 0, 0, 9, 32'h99, 0, 0, 5, 7, 32'hDEADBEEF, 0, 32'h33, 0, 1, 1);
    tv[10] = mk(1, 9, 3'b000, 0, 0, 0, 0, 0, 0,  9, 0, 32'h99, 1, 0, 0, 1, 1);
    tv[11] = mk(0, 0, 3'b101, 2, 32'h5, 0, 0, 9, 32'h1234, 5, 7, 32'hDEADBEEF, 0, 32'h33, 0, 0, 1);
    tv[12] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,  9, 2, 32'h1234, 0, 32'h5, 0, 0, 0);

    // Reset and verify every register reads zero and not pending
    idle(5'd0, 5'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_cnt", 32'(bus.pending_cnt), 32'd0);
    for (int i = 0; i < NREGS; i++) begin
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(NREGS - 1 - i);
      #1;
      chk("reset_rs1_data", bus.rs1_data, 32'd0);
      chk("reset_rs1_pend", 32'(bus.rs1_pending), 32'd0);
      chk("reset_rs2_data", bus.rs2_data, 32'd0);
      chk("reset_rs2_pend", 32'(bus.rs2_pending), 32'd0);
    end

    // Table-driven directed vectors
    next_cycle();
    for (int k = 0; k < 13; k++) begin
      drive(tv[k].ien, tv[k].ird, tv[k].wen, tv[k].wa0, tv[k].wd0, tv[k].wa1, tv[k].wd1,
            tv[k].wa2, tv[k].wd2, tv[k].rs1, tv[k].rs2);
      @(negedge clk);
      chk($sformatf("v%0d_rs1_data", k), bus.rs1_data, tv[k].e1d);
      chk($sformatf("v%0d_rs1_pend", k), 32'(bus.rs1_pending), 32'(tv[k].e1p));
      chk($sformatf("v%0d_rs2_data", k), bus.rs2_data, tv[k].e2d);
      chk($sformatf("v%0d_rs2_pend", k), 32'(bus.rs2_pending), 32'(tv[k].e2p));
      chk($sformatf("v%0d_waw", k), 32'(bus.issue_waw), 32'(tv[k].ewaw));
      chk($sformatf("v%0d_cnt", k), 32'(bus.pending_cnt), 32'(tv[k].ecnt));
      next_cycle();
    end

    // Forwarding: old reg3 = 1, issue 3, then write 0xA5A5A5A5 while reading rs1=3
    drive(1'b0, 5'd0, 3'b001, 5'd3, 32'h1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 5'd3, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd0);
    next_cycle();
    drive(1'b0, 5'd0, 3'b001, 5'd3, 32'hA5A5A5A5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_data", bus.rs1_data, 32'hA5A5A5A5);
    chk("byp_same_pend", 32'(bus.rs1_pending), 32'd0);
`else
    chk("byp_same_data", bus.rs1_data, 32'h1);
    chk("byp_same_pend", 32'(bus.rs1_pending), 32'd1);
`endif
    chk("byp_same_cnt", 32'(bus.pending_cnt), 32'd1);
    next_cycle();
    idle(5'd3, 5'd0);
    @(negedge clk);
    chk("byp_next_data", bus.rs1_data, 32'hA5A5A5A5);
    chk("byp_next_pend", 32'(bus.rs1_pending), 32'd0);
    chk("byp_next_cnt", 32'(bus.pending_cnt), 32'd0);
    next_cycle();

    // Issue rd=1..4 over four cycles, then assert reset mid-cycle
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 5'(r), 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd3);
      next_cycle();
    end
    idle(5'd1, 5'd3);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(bus.pending_cnt), 32'd4);
    chk("pre_rst_pend", 32'(bus.rs1_pending), 32'd1);
    chk("pre_rst_data", bus.rs2_data, 32'hA5A5A5A5);
    @(posedge clk);
    #2;
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("mid_rst_pend", 32'(bus.rs1_pending), 32'd0);
    chk("mid_rst_data", bus.rs2_data, 32'd0);
    chk("mid_rst_waw", 32'(bus.issue_waw), 32'd0);
    idle(5'd4, 5'd5);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("post_rst_pend", 32'(bus.rs1_pending), 32'd0);
    chk("post_rst_data", bus.rs2_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
